fpu_dispatch: RTL and testbench

- Multi-cycle sequencer between the core's FPU issue port and the combinational FPU datapath units (fadd, fmul, fdiv, fsqrt).
- Accepts one FPU operation per handshake and latches the operands onto the shared unit input buses.
- Holds the operands for a per-op settle latency, then captures result, ovf and udf into a 2-entry result queue drained by the writeback stage over valid/ready.
- Only one operation is in flight at a time.

---
 rtl/fpu_pkg.sv | 42 ++++
 rtl/fpu_res_fifo.sv | 55 +++++
 rtl/fpu_dispatch.sv | 150 +++++++++++++++
 tb/tb_fpu_dispatch.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types for the FPU dispatcher: opcodes, unit select, the canonical NaN
// and the result-queue entry.
package fpu_pkg;

  typedef enum logic [2:0] {
    FOP_ADD  = 3'd0,
    FOP_SUB  = 3'd1,
    FOP_MUL  = 3'd2,
    FOP_DIV  = 3'd3,
    FOP_SQRT = 3'd4
  } fpu_op_t;

  typedef enum logic [1:0] {
    SEL_ADD  = 2'd0,
    SEL_MUL  = 2'd1,
    SEL_DIV  = 2'd2,
    SEL_SQRT = 2'd3
  } unit_sel_t;

  localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;

  // Tag width of a queue entry; the top-level TAG_W defaults to this.
  localparam int FPU_TAG_W = 5;

  typedef struct packed {
    logic [31:0]          y;
    logic [FPU_TAG_W-1:0] tag;
    logic                 ovf;
    logic                 udf;
    logic                 ill;
  } fpu_res_t;

  function automatic unit_sel_t op_sel(fpu_op_t op);
    case (op)
      FOP_MUL:  return SEL_MUL;
      FOP_DIV:  return SEL_DIV;
      FOP_SQRT: return SEL_SQRT;
      default:  return SEL_ADD;
    endcase
  endfunction

endpackage

// File: rtl/fpu_res_fifo.sv
// Two-entry result queue; head entry is presented straight from storage so the
// outputs are registered and hold while not popped.
module fpu_res_fifo
  import fpu_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  fpu_res_t   wdata,
  input  logic       pop,
  output fpu_res_t   rdata,
  output logic [1:0] count
);

  fpu_res_t [1:0] mem_q, mem_d;
  logic           wr_ptr_q, wr_ptr_d;
  logic           rd_ptr_q, rd_ptr_d;
  logic [1:0]     count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // With count == 2 a simultaneous pop frees the slot being overwritten.
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fpu_dispatch.sv
// Sequencer between the FPU issue port and the combinational FPU units: latches
// operands, waits the per-op settle time, then queues the result for writeback.
module fpu_dispatch
  import fpu_pkg::*;
#(
  parameter int LAT_ADD  = 2,
  parameter int LAT_MUL  = 2,
  parameter int LAT_DIV  = 4,
  parameter int LAT_SQRT = 4,
  parameter int TAG_W    = FPU_TAG_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_x1,
  input  logic [31:0]      req_x2,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      unit_x1,
  output logic [31:0]      unit_x2,
  output logic [1:0]       unit_sel,
  input  logic [31:0]      unit_y,
  input  logic             unit_ovf,
  input  logic             unit_udf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_y,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_ovf,
  output logic             res_udf,
  output logic             res_ill,
  output logic             busy
);

  localparam int CNT_W = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      x1_q, x1_d, x2_q, x2_d;
  logic [1:0]       sel_q, sel_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic       push, pop;
  fpu_res_t   push_data, head;
  logic [1:0] q_count;

  function automatic logic [CNT_W-1:0] lat_of(fpu_op_t op);
    case (op)
      FOP_MUL:  return CNT_W'(LAT_MUL - 1);
      FOP_DIV:  return CNT_W'(LAT_DIV - 1);
      FOP_SQRT: return CNT_W'(LAT_SQRT - 1);
      default:  return CNT_W'(LAT_ADD - 1);
    endcase
  endfunction

  assign req_ready = (state_q == S_IDLE) && (q_count < 2'd2);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    sel_d     = sel_q;
    tag_d     = tag_q;
    push      = 1'b0;
    push_data = '0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          if (req_op > 3'd4) begin
            // Illegal ops never touch the units; they complete immediately.
            push          = 1'b1;
            push_data.y   = FP_CANON_NAN;
            push_data.tag = req_tag;
            push_data.ill = 1'b1;
          end else begin
            x1_d    = req_x1;
            x2_d    = (fpu_op_t'(req_op) == FOP_SUB)  ? {~req_x2[31], req_x2[30:0]} :
                      (fpu_op_t'(req_op) == FOP_SQRT) ? 32'd0 : req_x2;
            sel_d   = op_sel(fpu_op_t'(req_op));
            tag_d   = req_tag;
            cnt_d   = lat_of(fpu_op_t'(req_op));
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_CAPT;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_CAPT: begin
        // Slot was reserved at admission, so this push always fits.
        push          = 1'b1;
        push_data.y   = unit_y;
        push_data.tag = tag_q;
        push_data.ovf = unit_ovf;
        push_data.udf = unit_udf;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      sel_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      sel_q   <= sel_d;
      tag_q   <= tag_d;
    end
  end

  assign pop = res_valid && res_ready;

  fpu_res_fifo u_res_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (head),
    .count (q_count)
  );

  assign unit_x1   = x1_q;
  assign unit_x2   = x2_q;
  assign unit_sel  = sel_q;
  assign res_valid = (q_count != 2'd0);
  assign res_y     = head.y;
  assign res_tag   = head.tag;
  assign res_ovf   = head.ovf;
  assign res_udf   = head.udf;
  assign res_ill   = head.ill;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fpu_dispatch.sv
// Scoreboard bench for fpu_dispatch: expected results are queued at issue from
// a behavioural model and a monitor compares them as the queue drains.
module tb_fpu_dispatch;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_x1, req_x2;
  logic [4:0]  req_tag;
  logic [31:0] unit_x1, unit_x2, unit_y;
  logic [1:0]  unit_sel;
  logic        unit_ovf, unit_udf;
  logic        res_valid, res_ready;
  logic [31:0] res_y;
  logic [4:0]  res_tag;
  logic        res_ovf, res_udf, res_ill, busy;

  always #5 clk = ~clk;

  fpu_dispatch dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x1(req_x1), .req_x2(req_x2), .req_tag(req_tag),
    .unit_x1(unit_x1), .unit_x2(unit_x2), .unit_sel(unit_sel),
    .unit_y(unit_y), .unit_ovf(unit_ovf), .unit_udf(unit_udf),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_tag(res_tag),
    .res_ovf(res_ovf), .res_udf(res_udf), .res_ill(res_ill), .busy(busy)
  );

  // Stand-in FP units: arbitrary but deterministic functions of the operands.
  function automatic logic [31:0] ufn(logic [1:0] s, logic [31:0] a, logic [31:0] b);
    case (s)
      2'd0:    return a + b;
      2'd1:    return a * b;
      2'd2:    return a ^ {b[15:0], b[31:16]};
      default: return (a == 32'h4080_0000) ? 32'h4000_0000 : {1'b0, a[31:1]};
    endcase
  endfunction

  assign unit_y   = ufn(unit_sel, unit_x1, unit_x2);
  assign unit_ovf = (unit_sel == 2'd1) && (unit_x1[31:28] == 4'h7);
  assign unit_udf = (unit_sel == 2'd2) && (unit_x2[31:28] == 4'h0);

  typedef struct {
    logic [31:0] y;
    logic [4:0]  tag;
    logic        ovf, udf, ill;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0, n_bad = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled
  logic        hold_v = 1'b0;
  logic [31:0] hold_y;
  logic [4:0]  hold_tag;

  // Reference: what the writeback stage should receive for an issued op.
  function automatic exp_t expv(logic [2:0] op, logic [31:0] x1, logic [31:0] x2, logic [4:0] tag);
    exp_t e;
    logic [1:0] s;
    logic [31:0] b;
    e.tag = tag;
    if (op > 3'd4) begin
      e.y = 32'h7FC0_0000; e.ovf = 0; e.udf = 0; e.ill = 1;
      return e;
    end
    s = (op <= 3'd1) ? 2'd0 : (op == 3'd2) ? 2'd1 : (op == 3'd3) ? 2'd2 : 2'd3;
    b = (op == 3'd1) ? (x2 ^ 32'h8000_0000) : (op == 3'd4) ? 32'd0 : x2;
    e.y   = ufn(s, x1, b);
    e.ovf = (s == 2'd1) && (x1[31:28] == 4'h7);
    e.udf = (s == 2'd2) && (b[31:28] == 4'h0);
    e.ill = 1'b0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: owns res_ready; pops the scoreboard on every handshake.
  always @(negedge clk) begin
    if (hold_v && rstn) begin
      chk("hold_y", res_y, hold_y);
      chk("hold_tag", 32'(res_tag), 32'(hold_tag));
    end
    if (rdy_mode == 0)      res_ready = 1'b1;
    else if (rdy_mode == 2) res_ready = 1'b0;
    else                    res_ready = 1'($urandom_range(0, 1));
    if (rstn && res_valid && res_ready) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_result: got tag %0d y %h expected none", res_tag, res_y);
      end else begin
        mon_e = sbq.pop_front();
        chk("res_y", res_y, mon_e.y);
        chk("res_tag", 32'(res_tag), 32'(mon_e.tag));
        chk("res_ovf", 32'(res_ovf), 32'(mon_e.ovf));
        chk("res_udf", 32'(res_udf), 32'(mon_e.udf));
        chk("res_ill", 32'(res_ill), 32'(mon_e.ill));
      end
    end
    hold_v   = rstn && res_valid && !res_ready;
    hold_y   = res_y;
    hold_tag = res_tag;
  end

  // Returns just after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] x1, input logic [31:0] x2,
                       input logic [4:0] tag, input bit expect_it);
    int budget = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_x1 = x1; req_x2 = x2; req_tag = tag;
    while (!req_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: got req_ready 0 expected 1 within 200 cycles");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (expect_it) sbq.push_back(expv(op, x1, x2, tag));
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while ((sbq.size() != 0 || busy) && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    n_cmp++;
    if (sbq.size() != 0 || busy) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_op = '0; req_x1 = '0; req_x2 = '0; req_tag = '0;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_unit_x1", unit_x1, 0);
    chk("rst_unit_x2", unit_x2, 0);
    chk("rst_unit_sel", 32'(unit_sel), 0);
    chk("rst_res_y", res_y, 0);
    chk("rst_res_tag", 32'(res_tag), 0);
    chk("rst_res_ill", 32'(res_ill), 0);
    rstn = 1'b1;

    // fsqrt latency and busy window
    issue(3'd4, 32'h4080_0000, 32'h1234_5678, 5'd3, 1);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      chk("sqrt_busy", 32'(busy), (k < 5) ? 1 : 0);
      chk("sqrt_valid", 32'(res_valid), (k == 5) ? 1 : 0);
      if (k < 5) chk("sqrt_unit_x2", unit_x2, 0);
    end
    chk("sqrt_y", res_y, 32'h4000_0000);
    chk("sqrt_tag", 32'(res_tag), 3);
    drain();

    // fsub operand flip held through capture
    issue(3'd1, 32'h3F80_0000, 32'h3F80_0000, 5'd9, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("fsub_unit_x2", unit_x2, 32'hBF80_0000);
      chk("fsub_unit_x1", unit_x1, 32'h3F80_0000);
      chk("fsub_unit_sel", 32'(unit_sel), 0);
    end
    drain();

    // Queue fills with writeback stalled; first entry carries ovf, second not
    rdy_mode = 2;
    issue(3'd2, 32'h7000_0003, 32'h0000_0005, 5'd1, 1);
    issue(3'd2, 32'h0000_1234, 32'h0000_0011, 5'd2, 1);
    repeat (6) @(negedge clk);
    chk("full_req_ready", 32'(req_ready), 0);
    chk("full_res_valid", 32'(res_valid), 1);
    chk("full_head_tag", 32'(res_tag), 1);
    chk("full_head_ovf", 32'(res_ovf), 1);
    rdy_mode = 0;
    issue(3'd2, 32'h0000_00FF, 32'h0000_0003, 5'd4, 1);
    drain();

    // Illegal opcode completes next cycle
    issue(3'd6, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd7, 1);
    @(negedge clk);
    chk("ill_valid", 32'(res_valid), 1);
    chk("ill_flag", 32'(res_ill), 1);
    chk("ill_y", res_y, 32'h7FC0_0000);
    chk("ill_busy", 32'(busy), 0);
    chk("ill_req_ready", 32'(req_ready), 1);
    drain();

    // Reset during fdiv settle aborts it
    issue(3'd3, 32'h1111_2222, 32'h3333_4444, 5'd11, 0);
    repeat (2) @(negedge clk);
    chk("div_busy", 32'(busy), 1);
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_res_valid", 32'(res_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_req_ready", 32'(req_ready), 1);
    chk("abort_unit_x1", unit_x1, 0);
    rstn = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_stale", 32'(res_valid), 0);

    // Randomized mix, including illegal opcodes and a random writeback
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a[31:28] = 4'h7;
      if ($urandom_range(0, 3) == 0) b[31:28] = 4'h0;
      issue(3'($urandom_range(0, 7)), a, b, 5'($urandom), 1);
    end
    drain();
    rdy_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
